// File: rtl/regfile_mp.sv
// Multi-port integer register file with two write ports (pipeline WB and
// MUL/DIV writeback), same-cycle write bypass on every read port, and a
// per-register busy scoreboard with a registered busy-register count.
// x0 reads as zero and never holds a value or a busy mark; addresses at or
// above DEPTH behave the same way.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int NRD    = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NRD-1:0]           rd_en_i,
  input  logic [NRD*ADDR_W-1:0]    rd_addr_i,
  output logic [NRD*DATA_W-1:0]    rd_data_o,
  output logic [NRD-1:0]           rd_busy_o,
  input  logic                     w0_en_i,
  input  logic [ADDR_W-1:0]        w0_addr_i,
  input  logic [DATA_W-1:0]        w0_data_i,
  input  logic                     w1_en_i,
  input  logic [ADDR_W-1:0]        w1_addr_i,
  input  logic [DATA_W-1:0]        w1_data_i,
  input  logic                     bsy_set_i,
  input  logic [ADDR_W-1:0]        bsy_addr_i,
  output logic [ADDR_W:0]          bsy_cnt_o
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH - 1);

  // True for an address that names a real, writable register (not x0, below DEPTH).
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic [31:0] a32;
    a32 = 32'(a);
    return (a32 != 32'd0) && (a32 < DEPTH);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;
  logic              w0_ok_s;
  logic              w1_ok_s;
  logic              set_ok_s;
  logic              set_rise_s;
  logic              clr_fall_s;
  logic [ADDR_W-1:0] rd_addr_s [NRD];

  // Qualify each write/set request against x0 and out-of-range addresses.
  always_comb begin
    w0_ok_s  = w0_en_i   && addr_ok(w0_addr_i);
    w1_ok_s  = w1_en_i   && addr_ok(w1_addr_i);
    set_ok_s = bsy_set_i && addr_ok(bsy_addr_i);
  end

  // Scoreboard next state: a new issue beats a same-register completion.
  always_comb begin
    busy_d     = busy_q;
    set_rise_s = 1'b0;
    clr_fall_s = 1'b0;
    busy_d[0]  = 1'b0;
    for (int r = 1; r < DEPTH; r++) begin
      if (set_ok_s && (bsy_addr_i == ADDR_W'(r))) begin
        if (!busy_q[r]) begin
          set_rise_s = 1'b1;
        end else begin
          set_rise_s = set_rise_s;
        end
        busy_d[r] = 1'b1;
      end else if (w1_ok_s && (w1_addr_i == ADDR_W'(r))) begin
        if (busy_q[r]) begin
          clr_fall_s = 1'b1;
        end else begin
          clr_fall_s = clr_fall_s;
        end
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
  end

  // Busy count tracks net 0->1 minus 1->0 transitions, clamped to its range.
  always_comb begin
    cnt_d = cnt_q;
    if (set_rise_s && !clr_fall_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!set_rise_s && clr_fall_s && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Scoreboard and count registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bsy_cnt_o = cnt_q;

  // Register array update; w0 is younger in program order so it wins a collision.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        if (w0_ok_s && (w0_addr_i == ADDR_W'(r))) begin
          mem_q[r] <= w0_data_i;
        end else if (w1_ok_s && (w1_addr_i == ADDR_W'(r))) begin
          mem_q[r] <= w1_data_i;
        end
      end
    end
  end

  // Unpack the flat read-address bus into one address per port.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_addr_s[k] = rd_addr_i[k*ADDR_W +: ADDR_W];
    end
  end

  // Read ports: bypass w0 then w1, else the array; forced to zero in reset.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NRD; k++) begin
      if (rstn && rd_en_i[k] && addr_ok(rd_addr_s[k])) begin
        if (w0_en_i && (w0_addr_i == rd_addr_s[k])) begin
          rd_data_o[k*DATA_W +: DATA_W] = w0_data_i;
        end else if (w1_en_i && (w1_addr_i == rd_addr_s[k])) begin
          rd_data_o[k*DATA_W +: DATA_W] = w1_data_i;
        end else begin
          for (int r = 1; r < DEPTH; r++) begin
            if (rd_addr_s[k] == ADDR_W'(r)) begin
              rd_data_o[k*DATA_W +: DATA_W] = mem_q[r];
            end
          end
        end
        for (int r = 1; r < DEPTH; r++) begin
          if (rd_addr_s[k] == ADDR_W'(r)) begin
            rd_busy_o[k] = busy_q[r] && !(w1_en_i && (w1_addr_i == rd_addr_s[k]));
          end
        end
      end else begin
        rd_data_o[k*DATA_W +: DATA_W] = '0;
        rd_busy_o[k] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp with three read ports.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic              clk;
  logic              rstn;
  logic [NR-1:0]     rd_en_i;
  logic [NR*AW-1:0]  rd_addr_i;
  logic [NR*DW-1:0]  rd_data_o;
  logic [NR-1:0]     rd_busy_o;
  logic              w0_en_i;
  logic [AW-1:0]     w0_addr_i;
  logic [DW-1:0]     w0_data_i;
  logic              w1_en_i;
  logic [AW-1:0]     w1_addr_i;
  logic [DW-1:0]     w1_data_i;
  logic              bsy_set_i;
  logic [AW-1:0]     bsy_addr_i;
  logic [AW:0]       bsy_cnt_o;

  int checks;
  int failures;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32), .NRD(NR)) dut (
    .clk(clk), .rstn(rstn),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
    .w0_en_i(w0_en_i), .w0_addr_i(w0_addr_i), .w0_data_i(w0_data_i),
    .w1_en_i(w1_en_i), .w1_addr_i(w1_addr_i), .w1_data_i(w1_data_i),
    .bsy_set_i(bsy_set_i), .bsy_addr_i(bsy_addr_i),
    .bsy_cnt_o(bsy_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rdat(input int k);
    return rd_data_o[k*DW +: DW];
  endfunction

  task automatic idle();
    rd_en_i = '0; rd_addr_i = '0;
    w0_en_i = 1'b0; w0_addr_i = '0; w0_data_i = '0;
    w1_en_i = 1'b0; w1_addr_i = '0; w1_data_i = '0;
    bsy_set_i = 1'b0; bsy_addr_i = '0;
  endtask

  task automatic set_rd(input int k, input logic en, input logic [AW-1:0] a);
    rd_en_i[k] = en;
    rd_addr_i[k*AW +: AW] = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    set_rd(0, 1'b1, 5'd1);
    #2;
    checks++;
    if (bsy_cnt_o !== 6'd0) begin
      $display("FAIL reset_cnt got=%0d exp=0", bsy_cnt_o); failures++;
    end
    checks++;
    if (rdat(0) !== 32'h0) begin
      $display("FAIL reset_read got=%h exp=0", rdat(0)); failures++;
    end
    #10;
    rstn = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_x0();
    w0_en_i = 1'b1; w0_addr_i = 5'd0; w0_data_i = 32'hDEADBEEF;
    w1_en_i = 1'b1; w1_addr_i = 5'd0; w1_data_i = 32'hDEADBEEF;
    bsy_set_i = 1'b1; bsy_addr_i = 5'd0;
    set_rd(0, 1'b1, 5'd0);
    #1;
    checks++;
    if (rdat(0) !== 32'h0) begin
      $display("FAIL x0_bypass got=%h exp=0", rdat(0)); failures++;
    end
    tick();
    idle();
    set_rd(0, 1'b1, 5'd0);
    #1;
    checks++;
    if (rdat(0) !== 32'h0 || rd_busy_o[0] !== 1'b0) begin
      $display("FAIL x0_read got=%h busy=%b exp=0 busy=0", rdat(0), rd_busy_o[0]); failures++;
    end
    checks++;
    if (bsy_cnt_o !== 6'd0) begin
      $display("FAIL x0_cnt got=%0d exp=0", bsy_cnt_o); failures++;
    end
    tick();
  endtask

  task automatic test_bypass_priority();
    w0_en_i = 1'b1; w0_addr_i = 5'd5; w0_data_i = 32'h11;
    w1_en_i = 1'b1; w1_addr_i = 5'd5; w1_data_i = 32'h22;
    set_rd(0, 1'b1, 5'd5);
    set_rd(1, 1'b1, 5'd5);
    #1;
    checks++;
    if (rdat(0) !== 32'h11 || rdat(1) !== 32'h11) begin
      $display("FAIL bypass_prio got=%h,%h exp=11,11", rdat(0), rdat(1)); failures++;
    end
    tick();
    idle();
    set_rd(0, 1'b1, 5'd5);
    #1;
    checks++;
    if (rdat(0) !== 32'h11) begin
      $display("FAIL bypass_array got=%h exp=11", rdat(0)); failures++;
    end
    w1_en_i = 1'b1; w1_addr_i = 5'd6; w1_data_i = 32'h66;
    set_rd(1, 1'b1, 5'd6);
    #1;
    checks++;
    if (rdat(1) !== 32'h66) begin
      $display("FAIL bypass_w1 got=%h exp=66", rdat(1)); failures++;
    end
    tick();
    idle();
    set_rd(2, 1'b1, 5'd6);
    #1;
    checks++;
    if (rdat(2) !== 32'h66) begin
      $display("FAIL w1_array got=%h exp=66", rdat(2)); failures++;
    end
    tick();
  endtask

  task automatic test_scoreboard();
    idle();
    bsy_set_i = 1'b1; bsy_addr_i = 5'd7;
    tick();
    idle();
    set_rd(0, 1'b1, 5'd7);
    #1;
    checks++;
    if (rd_busy_o[0] !== 1'b1 || bsy_cnt_o !== 6'd1) begin
      $display("FAIL sb_set got busy=%b cnt=%0d exp busy=1 cnt=1", rd_busy_o[0], bsy_cnt_o); failures++;
    end
    w1_en_i = 1'b1; w1_addr_i = 5'd7; w1_data_i = 32'h1234;
    #1;
    checks++;
    if (rd_busy_o[0] !== 1'b0 || rdat(0) !== 32'h1234) begin
      $display("FAIL sb_complete got busy=%b data=%h exp busy=0 data=1234", rd_busy_o[0], rdat(0)); failures++;
    end
    tick();
    idle();
    set_rd(0, 1'b1, 5'd7);
    #1;
    checks++;
    if (bsy_cnt_o !== 6'd0 || rd_busy_o[0] !== 1'b0 || rdat(0) !== 32'h1234) begin
      $display("FAIL sb_clear got cnt=%0d busy=%b data=%h exp 0,0,1234", bsy_cnt_o, rd_busy_o[0], rdat(0)); failures++;
    end
    tick();
  endtask

  task automatic test_set_clear();
    idle();
    bsy_set_i = 1'b1; bsy_addr_i = 5'd3;
    tick();
    bsy_addr_i = 5'd9;
    tick();
    idle();
    #1;
    checks++;
    if (bsy_cnt_o !== 6'd2) begin
      $display("FAIL sc_pre got=%0d exp=2", bsy_cnt_o); failures++;
    end
    // re-issue x3 while it completes
    bsy_set_i = 1'b1; bsy_addr_i = 5'd3;
    w1_en_i = 1'b1; w1_addr_i = 5'd3; w1_data_i = 32'h33;
    set_rd(0, 1'b1, 5'd3);
    #1;
    checks++;
    if (rd_busy_o[0] !== 1'b0 || rdat(0) !== 32'h33) begin
      $display("FAIL sc_same_bypass got busy=%b data=%h exp 0,33", rd_busy_o[0], rdat(0)); failures++;
    end
    tick();
    idle();
    set_rd(0, 1'b1, 5'd3);
    #1;
    checks++;
    if (rd_busy_o[0] !== 1'b1 || bsy_cnt_o !== 6'd2) begin
      $display("FAIL sc_same got busy=%b cnt=%0d exp 1,2", rd_busy_o[0], bsy_cnt_o); failures++;
    end
    // set x4 while x9 completes
    bsy_set_i = 1'b1; bsy_addr_i = 5'd4;
    w1_en_i = 1'b1; w1_addr_i = 5'd9; w1_data_i = 32'h99;
    tick();
    idle();
    set_rd(0, 1'b1, 5'd4);
    set_rd(1, 1'b1, 5'd9);
    #1;
    checks++;
    if (bsy_cnt_o !== 6'd2 || rd_busy_o[0] !== 1'b1 || rd_busy_o[1] !== 1'b0) begin
      $display("FAIL sc_diff got cnt=%0d b4=%b b9=%b exp 2,1,0", bsy_cnt_o, rd_busy_o[0], rd_busy_o[1]); failures++;
    end
    // completion on a free register changes nothing
    w1_en_i = 1'b1; w1_addr_i = 5'd9; w1_data_i = 32'h98;
    tick();
    idle();
    #1;
    checks++;
    if (bsy_cnt_o !== 6'd2) begin
      $display("FAIL sc_free_clr got=%0d exp=2", bsy_cnt_o); failures++;
    end
    w1_en_i = 1'b1; w1_addr_i = 5'd3;
    tick();
    w1_addr_i = 5'd4;
    tick();
    idle();
    #1;
    checks++;
    if (bsy_cnt_o !== 6'd0) begin
      $display("FAIL sc_drain got=%0d exp=0", bsy_cnt_o); failures++;
    end
  endtask

  task automatic test_multiport();
    idle();
    w0_en_i = 1'b1; w0_addr_i = 5'd1; w0_data_i = 32'h101;
    tick();
    w0_addr_i = 5'd2; w0_data_i = 32'h202;
    tick();
    idle();
    set_rd(0, 1'b1, 5'd1);
    set_rd(1, 1'b0, 5'd2);
    set_rd(2, 1'b1, 5'd1);
    #1;
    checks++;
    if (rdat(0) !== 32'h101 || rdat(1) !== 32'h0 || rdat(2) !== 32'h101) begin
      $display("FAIL multiport got=%h,%h,%h exp=101,0,101", rdat(0), rdat(1), rdat(2)); failures++;
    end
    set_rd(1, 1'b1, 5'd2);
    #1;
    checks++;
    if (rdat(1) !== 32'h202) begin
      $display("FAIL multiport_p1 got=%h exp=202", rdat(1)); failures++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    idle();
    w0_en_i = 1'b1; w0_addr_i = 5'd10; w0_data_i = 32'hA0;
    tick();
    w0_addr_i = 5'd11; w0_data_i = 32'hB0;
    set_rd(0, 1'b1, 5'd10);
    set_rd(1, 1'b1, 5'd11);
    #1;
    checks++;
    if (rdat(0) !== 32'hA0 || rdat(1) !== 32'hB0) begin
      $display("FAIL b2b got=%h,%h exp=a0,b0", rdat(0), rdat(1)); failures++;
    end
    tick();
    idle();
    set_rd(0, 1'b1, 5'd11);
    #1;
    checks++;
    if (rdat(0) !== 32'hB0) begin
      $display("FAIL b2b_array got=%h exp=b0", rdat(0)); failures++;
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    idle();
    bsy_set_i = 1'b1; bsy_addr_i = 5'd12;
    tick();
    idle();
    w0_en_i = 1'b1; w0_addr_i = 5'd1; w0_data_i = 32'hFFFF;
    w1_en_i = 1'b1; w1_addr_i = 5'd5; w1_data_i = 32'h55;
    bsy_set_i = 1'b1; bsy_addr_i = 5'd13;
    set_rd(0, 1'b1, 5'd1);
    set_rd(1, 1'b1, 5'd12);
    set_rd(2, 1'b1, 5'd5);
    #1;
    rstn = 1'b0;
    #1;
    checks++;
    if (rd_data_o !== '0 || rd_busy_o !== '0 || bsy_cnt_o !== 6'd0) begin
      $display("FAIL midrun_reset got data=%h busy=%b cnt=%0d exp all 0", rd_data_o, rd_busy_o, bsy_cnt_o); failures++;
    end
    idle();
    #1;
    rstn = 1'b1;
    tick();
    set_rd(0, 1'b1, 5'd1);
    set_rd(1, 1'b1, 5'd12);
    set_rd(2, 1'b1, 5'd11);
    #1;
    checks++;
    if (rdat(0) !== 32'h0 || rdat(2) !== 32'h0 || rd_busy_o !== 3'b000 || bsy_cnt_o !== 6'd0) begin
      $display("FAIL post_reset got x1=%h x11=%h busy=%b cnt=%0d exp 0", rdat(0), rdat(2), rd_busy_o, bsy_cnt_o); failures++;
    end
    tick();
  endtask

  task automatic test_fill();
    idle();
    for (int r = 1; r < 32; r++) begin
      bsy_set_i = 1'b1; bsy_addr_i = AW'(r);
      tick();
      bsy_set_i = 1'b0;
      set_rd(0, 1'b1, AW'(r));
      #1;
      checks++;
      if (bsy_cnt_o !== 6'(r) || rd_busy_o[0] !== 1'b1) begin
        $display("FAIL fill_set r=%0d got cnt=%0d busy=%b exp cnt=%0d busy=1", r, bsy_cnt_o, rd_busy_o[0], r); failures++;
      end
    end
    bsy_set_i = 1'b1; bsy_addr_i = 5'd10;
    tick();
    bsy_set_i = 1'b0;
    #1;
    checks++;
    if (bsy_cnt_o !== 6'd31) begin
      $display("FAIL fill_reset_busy got=%0d exp=31", bsy_cnt_o); failures++;
    end
    for (int r = 1; r < 32; r++) begin
      w1_en_i = 1'b1; w1_addr_i = AW'(r); w1_data_i = 32'(r);
      tick();
      w1_en_i = 1'b0;
      #1;
      checks++;
      if (bsy_cnt_o !== 6'(31 - r)) begin
        $display("FAIL fill_clr r=%0d got=%0d exp=%0d", r, bsy_cnt_o, 31 - r); failures++;
      end
    end
    idle();
    set_rd(0, 1'b1, 5'd31);
    #1;
    checks++;
    if (rdat(0) !== 32'd31 || rd_busy_o[0] !== 1'b0) begin
      $display("FAIL fill_data got=%h busy=%b exp 1f,0", rdat(0), rd_busy_o[0]); failures++;
    end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle();
    test_reset();
    test_x0();
    test_bypass_priority();
    test_scoreboard();
    test_set_clear();
    test_multiport();
    test_back_to_back();
    test_reset_midrun();
    test_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
